// File: rtl/layer_sequencer.sv
// layer_sequencer: runs the read driver over layers 0..last_q, one layer at a
// time, waiting for read_done then sum_valid between layers.
// Optional watchdog on the wait states: define LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int MAX_LAYER      = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] last_layer,
  input  logic       abort,
  input  logic       read_done,
  input  logic       sum_valid,
  output logic       start,
  output logic [1:0] layer,
  output logic       busy,
  output logic       done,
  output logic [1:0] layers_done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_READ,
    WAIT_SUM,
    GAP,
    FINISH
  } state_t;

  localparam logic [1:0] MAX_L = 2'(MAX_LAYER);
  localparam int         GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state, state_n;
  logic [1:0]    last_q, last_n;
  logic [1:0]    layer_n, ld_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          to_n;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WW-1:0] wd_cnt, wd_n;
`endif

  // Next-state and next-value logic for the layer sequence
  always_comb begin
    state_n = state;
    last_n  = last_q;
    layer_n = layer;
    ld_n    = layers_done;
    gap_n   = gap_cnt;
    to_n    = timeout;
`ifdef LAYER_SEQ_TIMEOUT_EN
    wd_n    = wd_cnt;
`endif
    if (state != IDLE && abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            last_n  = (last_layer > MAX_L) ? MAX_L : last_layer;
            layer_n = '0;
            ld_n    = '0;
            to_n    = 1'b0;
            state_n = LAUNCH;
          end
        end
        LAUNCH: begin
          state_n = WAIT_READ;
`ifdef LAYER_SEQ_TIMEOUT_EN
          wd_n    = '0;
`endif
        end
        WAIT_READ: begin
          if (read_done) begin
            state_n = WAIT_SUM;
`ifdef LAYER_SEQ_TIMEOUT_EN
            wd_n    = '0;
          end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            to_n    = 1'b1;
            state_n = IDLE;
          end else begin
            wd_n    = wd_cnt + WW'(1);
`endif
          end
        end
        WAIT_SUM: begin
          if (sum_valid) begin
            ld_n = layers_done + 2'd1;
            if (layer == last_q) begin
              state_n = FINISH;
            end else begin
              layer_n = layer + 2'd1;
              gap_n   = '0;
              state_n = GAP;
            end
`ifdef LAYER_SEQ_TIMEOUT_EN
          end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            to_n    = 1'b1;
            state_n = IDLE;
          end else begin
            wd_n    = wd_cnt + WW'(1);
`endif
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = LAUNCH;
          else gap_n = gap_cnt + GW'(1);
        end
        FINISH:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers; start is registered off LAUNCH so the layer
  // index is already stable for a full cycle when the pulse reaches the driver
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_q      <= '0;
      layer       <= '0;
      layers_done <= '0;
      gap_cnt     <= '0;
      timeout     <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      state       <= state_n;
      last_q      <= last_n;
      layer       <= layer_n;
      layers_done <= ld_n;
      gap_cnt     <= gap_n;
      timeout     <= to_n;
      start       <= (state == LAUNCH) && !abort;
      busy        <= (state_n != IDLE);
      done        <= (state_n == FINISH);
`ifdef LAYER_SEQ_TIMEOUT_EN
      wd_cnt      <= wd_n;
`endif
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: event-scheduled reference model compared every
// cycle, plus literal latency/count checks on directed scenarios.
module tb_layer_sequencer;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int  TO    = 16;
  localparam bit  WD_EN = 1'b1;
`else
  localparam int  TO    = 255;
  localparam bit  WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, run = 1'b0, abort = 1'b0;
  logic       read_done = 1'b0, sum_valid = 1'b0;
  logic [1:0] last_layer = 2'd0;
  logic       start, busy, done, timeout;
  logic [1:0] layer, layers_done;

  layer_sequencer #(.MAX_LAYER(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .last_layer(last_layer),
    .abort(abort), .read_done(read_done), .sum_valid(sum_valid),
    .start(start), .layer(layer), .busy(busy), .done(done),
    .layers_done(layers_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks run progress as scheduled pulse cycles
  int m_busy = 0, m_layer = 0, m_ld = 0, m_last = 0, m_to = 0;
  int m_wait = 0, m_wait_from = 0;     // 0 none, 1 read_done, 2 sum_valid
  int m_start_due = -1, m_done_due = -1;

  always @(posedge clk) begin
    int n;
    n = cyc;
    cyc++;
    if (!reset) begin
      checking = 1'b1;
      m_busy = 0; m_layer = 0; m_ld = 0; m_last = 0; m_to = 0;
      m_wait = 0; m_start_due = -1; m_done_due = -1;
    end else if (m_busy != 0 && abort) begin
      m_busy = 0; m_wait = 0; m_start_due = -1; m_done_due = -1;
    end else if (m_busy == 0 && run) begin
      m_last = (last_layer > 2) ? 2 : int'(last_layer);
      m_layer = 0; m_ld = 0; m_to = 0; m_busy = 1;
      m_start_due = cyc + 1; m_wait = 1; m_wait_from = cyc + 1;
    end else if (m_busy != 0) begin
      if (n == m_done_due) begin
        m_busy = 0;
      end else if (m_wait == 1 && n >= m_wait_from) begin
        if (read_done) begin
          m_wait = 2; m_wait_from = cyc;
        end else if (WD_EN && n - m_wait_from + 1 == TO) begin
          m_to = 1; m_busy = 0; m_wait = 0;
        end
      end else if (m_wait == 2 && n >= m_wait_from) begin
        if (sum_valid) begin
          m_ld++;
          if (m_layer == m_last) begin
            m_done_due = cyc; m_wait = 0;
          end else begin
            m_layer++;
            m_start_due = cyc + 3; m_wait = 1; m_wait_from = cyc + 3;
          end
        end else if (WD_EN && n - m_wait_from + 1 == TO) begin
          m_to = 1; m_busy = 0; m_wait = 0;
        end
      end
    end
    #1;
    if (checking) begin
      chk("start", start, (cyc == m_start_due) ? 1 : 0);
      chk("done", done, (cyc == m_done_due) ? 1 : 0);
      chk("busy", busy, m_busy);
      chk("layer", layer, m_layer);
      chk("layers_done", layers_done, m_ld);
      chk("timeout", timeout, m_to);
    end
  end

  task automatic pulse_run(input logic [1:0] ll, output int rc);
    @(negedge clk); run = 1'b1; last_layer = ll; rc = cyc;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_start(output int s);
    bit ok;
    ok = 1'b0; s = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (start === 1'b1) begin s = cyc; ok = 1'b1; break; end
    end
    chk("start_seen", ok, 1);
  endtask

  // Answer a start seen in cycle s: read_done at s+12, sum_valid at s+15
  task automatic answer(input bit both, input bit poke_run, output int svc);
    repeat (12) @(negedge clk);
    read_done = 1'b1; sum_valid = both;
    @(negedge clk); read_done = 1'b0; sum_valid = 1'b0;
    @(negedge clk); run = poke_run;
    @(negedge clk); run = 1'b0; sum_valid = 1'b1; svc = cyc;
    @(negedge clk); sum_valid = 1'b0;
  endtask

  initial begin
    int rc, s, sv, sv0, cnt;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_layer", layer, 0);
    reset = 1'b1;

    // Full run over layers 0..2
    pulse_run(2'd2, rc);
    wait_start(s);
    chk("first_start_lat", s - rc, 2);
    chk("first_layer", layer, 0);
    sv0 = 0;
    for (int k = 0; k < 3; k++) begin
      answer(1'b0, k == 1, sv);
      if (k == 0) sv0 = sv;
      if (k < 2) begin
        wait_start(s);
        chk("layer_at_start", layer, k + 1);
        if (k == 0) chk("gap_latency", s - sv0, 4);
      end
    end
    chk("done_pulse", done, 1);
    chk("done_count", layers_done, 3);
    @(negedge clk);
    chk("busy_after_done", busy, 0);

    // Clamp: last_layer=3 runs layers 0..2 only
    pulse_run(2'd3, rc);
    for (int k = 0; k < 3; k++) begin
      wait_start(s);
      chk("clamp_layer", layer, k);
      answer(k == 0, 1'b0, sv);
    end
    chk("clamp_done", done, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start === 1'b1) cnt++;
    end
    chk("clamp_extra_starts", cnt, 0);

    // Abort together with read_done during layer 1
    pulse_run(2'd2, rc);
    wait_start(s);
    answer(1'b0, 1'b0, sv);
    wait_start(s);
    repeat (12) @(negedge clk);
    read_done = 1'b1; abort = 1'b1;
    @(negedge clk); read_done = 1'b0; abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_layer", layer, 1);
    chk("abort_ld", layers_done, 1);
    repeat (10) @(negedge clk);
    pulse_run(2'd1, rc);
    wait_start(s);
    chk("restart_layer", layer, 0);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;

    // Reset in WAIT_SUM, then stray pulses
    pulse_run(2'd2, rc);
    wait_start(s);
    repeat (12) @(negedge clk);
    read_done = 1'b1;
    @(negedge clk); read_done = 1'b0; reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_layer", layer, 0);
    repeat (2) @(negedge clk);
    sum_valid = 1'b1;
    @(negedge clk); sum_valid = 1'b0; read_done = 1'b1;
    @(negedge clk); read_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_stays_idle", busy, 0);

`ifdef LAYER_SEQ_TIMEOUT_EN
    // Watchdog: never answer read_done
    pulse_run(2'd2, rc);
    wait_start(s);
    repeat (TO) @(negedge clk);
    chk("wd_timeout", timeout, 1);
    chk("wd_busy", busy, 0);
    pulse_run(2'd0, rc);
    chk("wd_cleared", timeout, 0);
    wait_start(s);
    answer(1'b0, 1'b0, sv);
    chk("wd_run_done", done, 1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
